alu_rr_scheduler: RTL and testbench

//  Round-robin scheduler sharing one ALU instance (instruction_t IW in, 32-bit result out) among N_REQ requesters.

---
 rtl/alu_rr_scheduler.sv | 125 ++++++++++++
 tb/tb_alu_rr_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_rr_scheduler.sv
// Round-robin arbiter sharing one ALU among N_REQ requesters, one op in flight.
// Define ALU_RR_STATS_EN to enable saturating per-requester grant counters.
// Instruction word layout (opaque to the scheduler): {op[7:0], a[31:0], b[31:0]}.

`ifdef ALU_RR_STATS_EN
module alu_rr_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clock) begin
        if (reset)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + CNT_W'(1);
    end
endmodule
`endif

module alu_rr_scheduler #(
    parameter  int N_REQ   = 4,
    parameter  int ALU_LAT = 1,
    parameter  int CNT_W   = 16,
    parameter  int INST_W  = 72,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ-1:0][INST_W-1:0]  req_inst,
    output logic [N_REQ-1:0]              req_ready,
    output logic [INST_W-1:0]             alu_iw,
    input  logic [31:0]                   alu_result,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [31:0]                   rsp_result,
    output logic                          busy,
    output logic [N_REQ-1:0][CNT_W-1:0]   grant_cnt
);
    localparam int LAT_W = (ALU_LAT < 2) ? 1 : $clog2(ALU_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t           state;
    logic [ID_W-1:0]  rr_ptr;
    logic [LAT_W-1:0] lat_cnt;
    logic             found;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  idx;

    // Search starts just after the last winner so every pending requester
    // is reached within N_REQ grants.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && found)
            req_ready[win] = 1'b1;
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            alu_iw     <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rr_ptr     <= ID_W'(N_REQ - 1);
            lat_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: if (found) begin
                    alu_iw  <= req_inst[win];
                    rsp_id  <= win;
                    rr_ptr  <= win;
                    lat_cnt <= LAT_W'(ALU_LAT);
                    state   <= S_WAIT;
                end
                S_WAIT: if (lat_cnt != '0) begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                end else begin
                    rsp_result <= alu_result;
                    rsp_valid  <= 1'b1;
                    state      <= S_RESP;
                end
                S_RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_RR_STATS_EN
    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
        alu_rr_cnt #(.CNT_W(CNT_W)) u_cnt (
            .clock (clock),
            .reset (reset),
            .inc   (req_valid[i] & req_ready[i]),
            .cnt   (grant_cnt[i])
        );
    end
`else
    assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed bench for alu_rr_scheduler with a one-cycle registered ALU model.
// Built with CNT_W=2 so the saturating counter case is reachable with ALU_RR_STATS_EN.
module tb_alu_rr_scheduler;
    localparam int N_REQ  = 4;
    localparam int INST_W = 72;
    localparam int CNT_W  = 2;

    logic                         clock;
    logic                         reset;
    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ-1:0][INST_W-1:0] req_inst;
    logic [N_REQ-1:0]             req_ready;
    logic [INST_W-1:0]            alu_iw;
    logic [31:0]                  alu_result;
    logic                         rsp_valid;
    logic                         rsp_ready;
    logic [1:0]                   rsp_id;
    logic [31:0]                  rsp_result;
    logic                         busy;
    logic [N_REQ-1:0][CNT_W-1:0]  grant_cnt;

    int nvec = 0;
    int nerr = 0;

    alu_rr_scheduler #(.N_REQ(N_REQ), .ALU_LAT(1), .CNT_W(CNT_W), .INST_W(INST_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_inst   (req_inst),
        .req_ready  (req_ready),
        .alu_iw     (alu_iw),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy),
        .grant_cnt  (grant_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ALU stand-in: samples IW on an edge, result valid after that edge
    always_ff @(posedge clock) begin
        case (alu_iw[71:64])
            8'd0:    alu_result <= alu_iw[63:32] + alu_iw[31:0];
            8'd1:    alu_result <= alu_iw[63:32] - alu_iw[31:0];
            default: alu_result <= 32'd0;
        endcase
    end

    function automatic logic [INST_W-1:0] mk(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        return {op, a, b};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full op with rsp_ready=1, starting in IDLE with req_valid already driven.
    task automatic run_op(input string tag, input int exp_id, input logic [INST_W-1:0] exp_iw,
                          input logic [31:0] exp_res);
        logic [N_REQ-1:0] oh;
        oh = 4'b0001 << exp_id;
        #1;
        chk({tag, " req_ready"}, 128'(req_ready), 128'(oh));
        tick();
        chk({tag, " busy"}, 128'(busy), 128'(1'b1));
        chk({tag, " alu_iw"}, 128'(alu_iw), 128'(exp_iw));
        tick();
        chk({tag, " rsp_valid early"}, 128'(rsp_valid), 128'(1'b0));
        tick();
        chk({tag, " rsp_valid"}, 128'(rsp_valid), 128'(1'b1));
        chk({tag, " rsp_id"}, 128'(rsp_id), 128'(exp_id));
        chk({tag, " rsp_result"}, 128'(rsp_result), 128'(exp_res));
        tick();
        chk({tag, " idle"}, 128'({busy, rsp_valid}), 128'(2'b00));
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_inst  = '0;
        rsp_ready = 1'b1;
        tick();
        tick();
        chk("reset busy", 128'(busy), 128'(1'b0));
        chk("reset rsp_valid", 128'(rsp_valid), 128'(1'b0));
        chk("reset alu_iw", 128'(alu_iw), 128'(0));
        chk("reset rsp_id/result", 128'({rsp_id, rsp_result}), 128'(0));
        chk("reset grant_cnt", 128'(grant_cnt), 128'(0));
        reset = 1'b0;

        // 1: req2 alone, ADD 10+15
        req_inst[2] = mk(8'd0, 32'd10, 32'd15);
        req_valid   = 4'b0100;
        run_op("t1", 2, mk(8'd0, 32'd10, 32'd15), 32'd25);

        // 2: all valid after reset -> 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N_REQ; i++)
            req_inst[i] = mk(8'd0, 32'(i * 100), 32'(i + 1));
        req_valid = 4'b1111;
        run_op("t2 g0", 0, mk(8'd0, 32'd0,   32'd1), 32'd1);
        run_op("t2 g1", 1, mk(8'd0, 32'd100, 32'd2), 32'd102);
        run_op("t2 g2", 2, mk(8'd0, 32'd200, 32'd3), 32'd203);
        run_op("t2 g3", 3, mk(8'd0, 32'd300, 32'd4), 32'd304);
        run_op("t2 g0b", 0, mk(8'd0, 32'd0,  32'd1), 32'd1);

        // 3: SUB 20-5 from req1 with response back-pressure
        req_inst[1] = mk(8'd1, 32'd20, 32'd5);
        req_valid   = 4'b0010;
        rsp_ready   = 1'b0;
        #1;
        chk("t3 req_ready", 128'(req_ready), 128'(4'b0010));
        tick();
        req_valid = 4'b1111;
        tick();
        tick();
        for (int c = 0; c < 5; c++) begin
            chk("t3 hold rsp_valid", 128'(rsp_valid), 128'(1'b1));
            chk("t3 hold id/result", 128'({rsp_id, rsp_result}), 128'({2'd1, 32'd15}));
            chk("t3 hold req_ready", 128'(req_ready), 128'(4'b0000));
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("t3 idle", 128'({busy, rsp_valid}), 128'(2'b00));
        req_valid = 4'b0000;

        // 4: req0 granted, then 1001 -> req3 then req0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_inst[1] = mk(8'd0, 32'd100, 32'd2);
        req_valid = 4'b0001;
        run_op("t4 g0", 0, mk(8'd0, 32'd0, 32'd1), 32'd1);
        req_valid = 4'b1001;
        run_op("t4 g3", 3, mk(8'd0, 32'd300, 32'd4), 32'd304);
        run_op("t4 g0b", 0, mk(8'd0, 32'd0, 32'd1), 32'd1);

        // 5: reset while waiting on the ALU
        req_valid = 4'b0100;
        tick();
        chk("t5 in wait", 128'(busy), 128'(1'b1));
        reset     = 1'b1;
        req_valid = 4'b0000;
        tick();
        reset = 1'b0;
        chk("t5 post-reset", 128'({busy, rsp_valid}), 128'(2'b00));
        chk("t5 alu_iw", 128'(alu_iw), 128'(0));
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5 no response", 128'(rsp_valid), 128'(1'b0));
        end
        req_valid = 4'b1111;
        run_op("t5 g0", 0, mk(8'd0, 32'd0, 32'd1), 32'd1);

        // 6: five ops from req1 -> counter saturates at 3 (2-bit)
        req_valid = 4'b0000;
        reset     = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6 cnt cleared", 128'(grant_cnt), 128'(0));
        req_inst[1] = mk(8'd1, 32'd20, 32'd5);
        req_valid   = 4'b0010;
        for (int n = 0; n < 5; n++)
            run_op("t6 op", 1, mk(8'd1, 32'd20, 32'd5), 32'd15);
`ifdef ALU_RR_STATS_EN
        chk("t6 grant_cnt", 128'(grant_cnt), 128'(8'b00_00_11_00));
`else
        chk("t6 grant_cnt", 128'(grant_cnt), 128'(0));
`endif
        req_valid = 4'b0000;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
